// File: rtl/ed25519_keygen_if.sv
// Handshake and data bundle between the key-derivation sequencer, the host
// key-load path, the SHA-512 engine and the scalar-mult engine.
interface ed25519_keygen_seq_if;
    logic         seed_valid;
    logic         seed_ready;
    logic [255:0] seed_data;
    logic         sha_req_valid;
    logic         sha_req_ready;
    logic [255:0] sha_msg;
    logic         sha_digest_valid;
    logic [511:0] sha_digest;
    logic         sm_req_valid;
    logic         sm_req_ready;
    logic [255:0] sm_scalar;
    logic         sm_done;
    logic [255:0] sm_point;
    logic         key_valid;
    logic         key_ready;
    logic [255:0] key_scalar;
    logic [255:0] key_prefix;
    logic [255:0] key_pub;
    logic         busy;
    logic         err_timeout;

    // Environment side: host, engines and key consumer.
    modport master (
        output seed_valid, seed_data, sha_req_ready, sha_digest_valid, sha_digest,
               sm_req_ready, sm_done, sm_point, key_ready,
        input  seed_ready, sha_req_valid, sha_msg, sm_req_valid, sm_scalar,
               key_valid, key_scalar, key_prefix, key_pub, busy, err_timeout
    );

    // Sequencer side.
    modport slave (
        input  seed_valid, seed_data, sha_req_ready, sha_digest_valid, sha_digest,
               sm_req_ready, sm_done, sm_point, key_ready,
        output seed_ready, sha_req_valid, sha_msg, sm_req_valid, sm_scalar,
               key_valid, key_scalar, key_prefix, key_pub, busy, err_timeout
    );
endinterface

// File: rtl/ed25519_keygen_seq.sv
// Ed25519 key derivation sequencer: seed -> SHA-512 -> clamp -> base-point mult.
// Seed accept to hash request 1 cycle, digest to mult request 2, sm_done to key 1; requests and key held until accepted.
module ed25519_keygen_seq #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ed25519_keygen_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE, HASH_REQ, HASH_WAIT, CLAMP, MULT_REQ, MULT_WAIT, DONE, ABORT
    } state_t;

    state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [255:0] seed_q, seed_d;
    logic [511:0] digest_q, digest_d;
    logic [255:0] scalar_q, scalar_d;
    logic [255:0] prefix_q, prefix_d;
    logic [255:0] pub_q, pub_d;
    logic         seed_rdy_q, seed_rdy_d;
    logic         sha_req_vld_q, sha_req_vld_d;
    logic         sm_req_vld_q, sm_req_vld_d;
    logic         key_vld_q, key_vld_d;
    logic         busy_q, busy_d;
    logic         err_tmo_q, err_tmo_d;
    logic         tmo_hit;

    assign cnt_inc = cnt_q + 1'b1;
    assign tmo_hit = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        seed_d   = seed_q;
        digest_d = digest_q;
        scalar_d = scalar_q;
        prefix_d = prefix_q;
        pub_d    = pub_q;
        case (state_q)
            IDLE: begin
                if (bus.seed_valid) begin
                    seed_d  = bus.seed_data;
                    cnt_d   = '0;
                    state_d = HASH_REQ;
                end
            end
            HASH_REQ: begin
                if (bus.sha_req_ready) state_d = HASH_WAIT;
            end
            HASH_WAIT: begin
                cnt_d = cnt_inc;
                // A strobe arriving on the timeout cycle still completes the job.
                if (bus.sha_digest_valid) begin
                    digest_d = bus.sha_digest;
                    state_d  = CLAMP;
                end else if (tmo_hit) begin
                    state_d = ABORT;
                end
            end
            CLAMP: begin
                scalar_d = {2'b01, digest_q[253:3], 3'b000};
                prefix_d = digest_q[511:256];
                cnt_d    = '0;
                state_d  = MULT_REQ;
            end
            MULT_REQ: begin
                if (bus.sm_req_ready) state_d = MULT_WAIT;
            end
            MULT_WAIT: begin
                cnt_d = cnt_inc;
                if (bus.sm_done) begin
                    pub_d   = bus.sm_point;
                    state_d = DONE;
                end else if (tmo_hit) begin
                    state_d = ABORT;
                end
            end
            DONE: begin
                if (bus.key_ready) begin
                    seed_d   = '0;
                    digest_d = '0;
                    scalar_d = '0;
                    prefix_d = '0;
                    pub_d    = '0;
                    state_d  = IDLE;
                end
            end
            ABORT: begin
                seed_d   = '0;
                digest_d = '0;
                scalar_d = '0;
                prefix_d = '0;
                pub_d    = '0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        seed_rdy_d    = (state_d == IDLE);
        sha_req_vld_d = (state_d == HASH_REQ);
        sm_req_vld_d  = (state_d == MULT_REQ);
        key_vld_d     = (state_d == DONE);
        busy_d        = (state_d != IDLE);
        err_tmo_d     = (state_d == ABORT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            seed_q        <= '0;
            digest_q      <= '0;
            scalar_q      <= '0;
            prefix_q      <= '0;
            pub_q         <= '0;
            seed_rdy_q    <= 1'b1;
            sha_req_vld_q <= 1'b0;
            sm_req_vld_q  <= 1'b0;
            key_vld_q     <= 1'b0;
            busy_q        <= 1'b0;
            err_tmo_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            seed_q        <= seed_d;
            digest_q      <= digest_d;
            scalar_q      <= scalar_d;
            prefix_q      <= prefix_d;
            pub_q         <= pub_d;
            seed_rdy_q    <= seed_rdy_d;
            sha_req_vld_q <= sha_req_vld_d;
            sm_req_vld_q  <= sm_req_vld_d;
            key_vld_q     <= key_vld_d;
            busy_q        <= busy_d;
            err_tmo_q     <= err_tmo_d;
        end
    end

    assign bus.seed_ready    = seed_rdy_q;
    assign bus.sha_req_valid = sha_req_vld_q;
    assign bus.sha_msg       = seed_q;
    assign bus.sm_req_valid  = sm_req_vld_q;
    assign bus.sm_scalar     = scalar_q;
    assign bus.key_valid     = key_vld_q;
    // Key material is only visible while it is being offered.
    assign bus.key_scalar    = key_vld_q ? scalar_q : '0;
    assign bus.key_prefix    = key_vld_q ? prefix_q : '0;
    assign bus.key_pub       = key_vld_q ? pub_q    : '0;
    assign bus.busy          = busy_q;
    assign bus.err_timeout   = err_tmo_q;

endmodule

// File: tb/tb_ed25519_keygen_seq.sv
// Randomized bench for the key-derivation sequencer with stub engines and a clamp reference model.
module tb_ed25519_keygen_seq;

    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n_err = 0;
    int   n_accept = 0;
    int   jobs = 0;

    ed25519_keygen_seq_if bus();

    ed25519_keygen_seq #(.TIMEOUT_CYCLES(TMO), .CNT_W(13)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.err_timeout) n_err <= n_err + 1;
        if (rst_n && bus.seed_valid && bus.seed_ready) n_accept <= n_accept + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Ed25519 clamp expressed arithmetically: round down to a multiple of 8,
    // force the value into [2^254, 2^255).
    function automatic logic [255:0] clamp_ref(input logic [511:0] d);
        logic [255:0] lo, b255, b254;
        b255 = 256'd1 << 255;
        b254 = 256'd1 << 254;
        lo   = d[255:0];
        lo   = lo - (lo % 256'd8);
        if (lo >= b255) lo = lo - b255;
        if (lo < b254) lo = lo + b254;
        return lo;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 512'(bus.busy), 512'd0);
        chk({tag, "_seed_ready"}, 512'(bus.seed_ready), 512'd1);
        chk({tag, "_sha_msg"}, 512'(bus.sha_msg), 512'd0);
        chk({tag, "_sm_scalar"}, 512'(bus.sm_scalar), 512'd0);
        chk({tag, "_key_valid"}, 512'(bus.key_valid), 512'd0);
        chk({tag, "_key_pub"}, 512'(bus.key_pub), 512'd0);
    endtask

    // Entered on the negedge right after the engine handshake (wait cycle 0).
    task automatic wait_tmo(input string tag, input int err0);
        int first;
        bit seen_key;
        first = -1;
        seen_key = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.err_timeout && first < 0) first = n;
            if (bus.key_valid) seen_key = 1'b1;
            @(negedge clk);
        end
        chk({tag, "_cycle"}, 512'(first), 512'(TMO));
        chk({tag, "_pulses"}, 512'(n_err - err0), 512'd1);
        chk({tag, "_no_key"}, 512'(seen_key), 512'd0);
        check_idle(tag);
    endtask

    // mode: 0 normal, 1 hash timeout, 2 mult timeout, 3 reset during mult wait
    task automatic do_job(input logic [255:0] seed, input logic [511:0] dig, input logic [255:0] pt,
                          input int sha_stall, input int dig_dly, input int sm_stall,
                          input int sm_dly, input int key_stall, input int mode, input bit hold);
        logic [255:0] exp_sc;
        int k;
        int err0;
        exp_sc = clamp_ref(dig);
        err0 = n_err;
        jobs++;
        bus.seed_data  = seed;
        bus.seed_valid = 1'b1;
        k = 0;
        while (!bus.seed_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("seed_ready_wait", 512'(k < 100), 512'd1);
        @(negedge clk);
        if (hold) bus.seed_data = {8{$urandom}};
        else      bus.seed_valid = 1'b0;
        chk("sha_req_lat", 512'(bus.sha_req_valid), 512'd1);
        chk("sha_msg", 512'(bus.sha_msg), 512'(seed));
        chk("seed_ready_busy", 512'(bus.seed_ready), 512'd0);
        for (int i = 0; i < sha_stall; i++) begin
            @(negedge clk);
            chk("sha_req_hold", 512'(bus.sha_req_valid), 512'd1);
            chk("sha_msg_hold", 512'(bus.sha_msg), 512'(seed));
            chk("sha_stall_no_tmo", 512'(bus.err_timeout), 512'd0);
        end
        bus.sha_req_ready = 1'b1;
        @(negedge clk);
        bus.sha_req_ready = 1'b0;
        if (mode == 1) begin
            wait_tmo("hash_tmo", err0);
            return;
        end
        repeat (dig_dly) @(negedge clk);
        chk("sha_req_drop", 512'(bus.sha_req_valid), 512'd0);
        bus.sha_digest       = dig;
        bus.sha_digest_valid = 1'b1;
        @(negedge clk);
        bus.sha_digest_valid = 1'b0;
        bus.sha_digest       = {16{$urandom}};
        chk("sm_req_early", 512'(bus.sm_req_valid), 512'd0);
        @(negedge clk);
        chk("sm_req_lat", 512'(bus.sm_req_valid), 512'd1);
        chk("sm_scalar", 512'(bus.sm_scalar), 512'(exp_sc));
        chk("prefix_hidden", 512'(bus.key_prefix), 512'd0);
        for (int i = 0; i < sm_stall; i++) begin
            @(negedge clk);
            chk("sm_req_hold", 512'(bus.sm_req_valid), 512'd1);
            chk("sm_scalar_hold", 512'(bus.sm_scalar), 512'(exp_sc));
        end
        bus.sm_req_ready = 1'b1;
        @(negedge clk);
        bus.sm_req_ready = 1'b0;
        if (mode == 2) begin
            wait_tmo("mult_tmo", err0);
            return;
        end
        if (mode == 3) begin
            repeat (3) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("rst_busy", 512'(bus.busy), 512'd0);
            chk("rst_sm_req", 512'(bus.sm_req_valid), 512'd0);
            chk("rst_sm_scalar", 512'(bus.sm_scalar), 512'd0);
            chk("rst_sha_msg", 512'(bus.sha_msg), 512'd0);
            chk("rst_key_valid", 512'(bus.key_valid), 512'd0);
            chk("rst_err", 512'(bus.err_timeout), 512'd0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check_idle("rst_release");
            chk("rst_no_err", 512'(n_err - err0), 512'd0);
            return;
        end
        // A stray digest strobe outside HASH_WAIT must not disturb the job.
        for (int i = 0; i < sm_dly; i++) begin
            bus.sha_digest_valid = (i == 0);
            bus.sha_digest       = {16{$urandom}};
            @(negedge clk);
        end
        bus.sha_digest_valid = 1'b0;
        bus.sm_point = pt;
        bus.sm_done  = 1'b1;
        @(negedge clk);
        bus.sm_done  = 1'b0;
        bus.sm_point = {8{$urandom}};
        chk("key_valid", 512'(bus.key_valid), 512'd1);
        chk("key_scalar", 512'(bus.key_scalar), 512'(exp_sc));
        chk("key_prefix", 512'(bus.key_prefix), 512'(dig[511:256]));
        chk("key_pub", 512'(bus.key_pub), 512'(pt));
        for (int i = 0; i < key_stall; i++) begin
            @(negedge clk);
            chk("key_valid_hold", 512'(bus.key_valid), 512'd1);
            chk("key_scalar_hold", 512'(bus.key_scalar), 512'(exp_sc));
            chk("key_prefix_hold", 512'(bus.key_prefix), 512'(dig[511:256]));
            chk("key_pub_hold", 512'(bus.key_pub), 512'(pt));
        end
        bus.key_ready = 1'b1;
        @(negedge clk);
        bus.key_ready = 1'b0;
        chk("key_prefix_zero", 512'(bus.key_prefix), 512'd0);
        check_idle("done");
        chk("done_no_err", 512'(n_err - err0), 512'd0);
    endtask

    initial begin
        logic [511:0] d;
        bus.seed_valid = 1'b0;
        bus.seed_data = '0;
        bus.sha_req_ready = 1'b0;
        bus.sha_digest_valid = 1'b0;
        bus.sha_digest = '0;
        bus.sm_req_ready = 1'b0;
        bus.sm_done = 1'b0;
        bus.sm_point = '0;
        bus.key_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_sha_req", 512'(bus.sha_req_valid), 512'd0);
        chk("reset_err", 512'(bus.err_timeout), 512'd0);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_seed_ready", 512'(bus.seed_ready), 512'd1);

        do_job(256'd1, {512{1'b1}}, {32{8'hA5}}, 0, 0, 0, 0, 0, 0, 1'b0);
        chk("ones_clamp_const", 512'(clamp_ref({512{1'b1}})), 512'({1'b0, {252{1'b1}}, 3'b000}));
        do_job({8{$urandom}}, 512'd0, {8{$urandom}}, 0, 2, 1, 3, 0, 0, 1'b0);
        do_job({8{$urandom}}, {16{$urandom}}, {8{$urandom}}, 20, 1, 0, 2, 20, 0, 1'b0);
        do_job({8{$urandom}}, {16{$urandom}}, {8{$urandom}}, 1, 3, 2, 4, 1, 2, 1'b0);
        do_job({8{$urandom}}, {16{$urandom}}, {8{$urandom}}, 2, 0, 0, 0, 0, 1, 1'b0);
        do_job({8{$urandom}}, {16{$urandom}}, {8{$urandom}}, 0, 4, 1, TMO - 1, 2, 0, 1'b0);
        do_job({8{$urandom}}, {16{$urandom}}, {8{$urandom}}, 0, 1, 0, 1, 0, 3, 1'b0);
        do_job({8{$urandom}}, {16{$urandom}}, {8{$urandom}}, 3, 5, 2, 2, 3, 0, 1'b1);
        do_job({8{$urandom}}, {16{$urandom}}, {8{$urandom}}, 1, 2, 1, 5, 1, 0, 1'b1);
        for (int r = 0; r < 6; r++) begin
            d = {16{$urandom}};
            do_job({8{$urandom}}, d, {8{$urandom}}, $urandom_range(0, 6), $urandom_range(0, 10),
                   $urandom_range(0, 6), $urandom_range(0, 10), $urandom_range(0, 6), 0, 1'b0);
        end
        chk("accept_count", 512'(n_accept), 512'(jobs));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ed25519_keygen_seq.md
Name: ed25519_keygen_seq

Overview:
- Sequences Ed25519 key derivation from a 32-byte seed.
- Flow: accept seed, issue a SHA-512 job, clamp the low half of the digest, issue a base-point scalar-mult job, return scalar, prefix and public key.
- Sits between the host key-load interface and the shared SHA-512 and scalar-mult engines. One key in flight at a time.

Parameters:
- TIMEOUT_CYCLES, 4096: max cycles spent in either engine-wait state before abort.
- CNT_W, 13: timeout counter width. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seed_valid  in  1  seed offer
- seed_ready  out  1  high only in IDLE
- seed_data  in  256  seed, byte 0 at [7:0]
- sha_req_valid  out  1  SHA-512 job request
- sha_req_ready  in  1  engine accepts job
- sha_msg  out  256  message to hash (registered seed)
- sha_digest_valid  in  1  one-cycle digest strobe
- sha_digest  in  512  digest, byte 0 at [7:0]
- sm_req_valid  out  1  scalar-mult job request
- sm_req_ready  in  1  engine accepts job
- sm_scalar  out  256  clamped scalar
- sm_done  in  1  one-cycle result strobe
- sm_point  in  256  encoded public point
- key_valid  out  1  result available
- key_ready  in  1  consumer accepts result
- key_scalar  out  256  clamped scalar
- key_prefix  out  256  digest[511:256]
- key_pub  out  256  public key
- busy  out  1  state != IDLE
- err_timeout  out  1  one-cycle abort pulse

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - All valid outputs and err_timeout = 0.
  - All 256-bit data registers = 0.
  - Timeout counter = 0.
- IDLE: seed_ready=1. On seed_valid&seed_ready, register seed_data into sha_msg, clear counter, go to HASH_REQ.
- HASH_REQ: sha_req_valid=1, sha_msg stable. On sha_req_ready, go to HASH_WAIT. The valid is not dropped until the handshake completes. No timeout in this state.
- HASH_WAIT:
  - Counter increments every cycle.
  - On sha_digest_valid, register the digest, go to CLAMP. Digest strobes seen in any other state are ignored.
  - If the counter reaches TIMEOUT_CYCLES before the digest arrives, go to ABORT. If the digest strobe and the timeout occur in the same cycle, the digest wins.
- CLAMP (exactly 1 cycle):
  - scalar = digest[255:0] with bits [2:0] cleared, bit 255 cleared, bit 254 set. All other bits pass through.
  - prefix = digest[511:256].
  - Clear the counter, go to MULT_REQ.
- MULT_REQ: sm_req_valid=1, sm_scalar stable. On sm_req_ready, go to MULT_WAIT.
- MULT_WAIT:
  - Counter increments.
  - On sm_done, register sm_point, go to DONE.
  - Timeout rule is the same as HASH_WAIT, with sm_done taking priority over the timeout.
- DONE:
  - key_valid=1.
  - key_scalar, key_prefix and key_pub are held stable until key_valid&key_ready.
  - On that handshake, go to IDLE and zeroize the seed, digest, scalar, prefix and pub registers in the same cycle.
- ABORT (1 cycle): err_timeout=1, zeroize all data registers, go to IDLE. key_valid is never asserted for an aborted job.
- Zeroization: key_* outputs read 0 whenever key_valid=0.
- Latency (engines respond immediately):
  - seed accept to sha_req_valid: 1 cycle.
  - Digest strobe to sm_req_valid: 2 cycles (register, then CLAMP).
  - sm_done to key_valid: 1 cycle.
- A seed offered while busy is not accepted (seed_ready=0). The sender holds it.
- Reset asserted mid-job returns to IDLE immediately with all registers zeroed. No err_timeout pulse.

Test Plan:
- Reset values: assert rst_n=0 mid-MULT_WAIT -> all outputs 0, busy=0, seed_ready=1 on release.
- All-ones digest:
  - Seed 0x00..01, engine stub returns digest all-ones -> sm_scalar = 0x7FFF..FFF8, key_prefix = all-ones.
  - Stub sm_point = 0xA5..A5 -> key_pub = 0xA5..A5.
  - sm_req_valid rises exactly 2 cycles after the digest strobe.
- All-zero digest: digest 0 -> sm_scalar = 0x4000..0000, key_prefix = 0.
- Backpressure:
  - Hold sha_req_ready=0 for 10 cycles -> sha_req_valid and sha_msg stay stable, and no timeout occurs.
  - Hold key_ready=0 for 20 cycles -> key_* outputs stay stable.
  - Then key_ready=1 -> key_* read 0 next cycle, seed_ready=1.
- Timeout:
  - TIMEOUT_CYCLES=16, no sm_done -> err_timeout pulses once ~16 cycles into MULT_WAIT, key_valid never asserts, IDLE follows.
  - A second variant drives sm_done on the timeout cycle -> normal completion with no err_timeout.
- Busy rejection: drive seed_valid continuously during a job -> exactly one seed accepted per completed job, and sha_msg unchanged mid-job.
